// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_AW           = 32;
  localparam int unsigned DEF_DW           = 32;
  localparam int unsigned DEF_MAX_D_STREAK = 4;
  localparam int unsigned STREAK_W         = 4;
  localparam int unsigned PERF_W           = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants; flags when fetch must win next.
module arb_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_MAX_D_STREAK
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic limit_c
);

  logic [STREAK_W-1:0] count_q;
  logic [STREAK_W-1:0] count_d;

  assign limit_c = (count_q == STREAK_W'(LIMIT));

  // Clear wins over increment; increment stops at the limit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !limit_c) begin
      count_d = count_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM stage accesses onto one variable-latency memory port.
// Optional MEM_ARB_PERF_EN adds per-requester wait-cycle counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_if_wait,
  output logic [PERF_W-1:0] perf_d_wait
`endif
);

  arb_state_e    state_q, state_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;

  logic          streak_clr;
  logic          streak_inc;
  logic          force_fetch_c;
  logic          grant_vld_c;
  arb_owner_e    grant_own_c;

  arb_streak_counter #(
    .LIMIT (MAX_D_STREAK)
  ) u_streak (
    .clk     (clk),
    .reset   (reset),
    .clr     (streak_clr),
    .inc     (streak_inc),
    .limit_c (force_fetch_c)
  );

  // Data wins unless a pending fetch has already waited out the streak limit.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_own_c = OWN_I;
    if (d_req && !(if_req && force_fetch_c)) begin
      grant_vld_c = 1'b1;
      grant_own_c = OWN_D;
    end else if (if_req) begin
      grant_vld_c = 1'b1;
      grant_own_c = OWN_I;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    streak_clr  = 1'b0;
    streak_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          mem_valid_d = 1'b1;
          if (grant_own_c == OWN_D) begin
            state_d     = BUSY_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            streak_inc  = if_req;
            streak_clr  = !if_req;
          end else begin
            state_d     = BUSY_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_clr  = 1'b1;
          end
        end
      end

      BUSY_I: begin
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          if_rdata_d  = mem_rdata;
          if_done_d   = 1'b1;
        end
      end

      // Stores leave d_rdata holding the last load value.
      BUSY_D: begin
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          d_done_d    = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] perf_if_q, perf_if_d;
  logic [PERF_W-1:0] perf_d_q, perf_d_d;

  // Wait cycles: request raised but its done pulse not yet seen; wraps freely.
  always_comb begin
    perf_if_d = perf_if_q + PERF_W'(if_req && !if_done_q);
    perf_d_d  = perf_d_q + PERF_W'(d_req && !d_done_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_d_q  <= perf_d_d;
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_d_wait  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, latency-programmable memory.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dop_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_d_wait;
`endif

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_d_wait  (perf_d_wait)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [31:0] if_ops[$];
  dop_t d_ops[$];

  int   mem_lat = 0;
  int   wcnt = 0;
  int   last_stalls = 0;
  logic [31:0] lat_addr, lat_wdata, last_addr, last_wdata;
  logic        lat_we, last_we;
  int   if_done_cyc = 0;
  int   d_done_cyc = 0;
  int   d_done_cnt = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Backing store contents as seen by the arbiter.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0000_0513 : a + 32'h1000_0000;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || if_ops.size() != 0 || d_ops.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s: drain timeout, %0d responses still expected", name, exp_q.size());
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: hold a level request for the front op until its done pulse.
  always @(posedge clk) begin
    #1;
    if_req  = (if_ops.size() > 0);
    if_addr = (if_ops.size() > 0) ? if_ops[0] : 32'h0;
    d_req   = (d_ops.size() > 0);
    d_we    = (d_ops.size() > 0) ? d_ops[0].we : 1'b0;
    d_addr  = (d_ops.size() > 0) ? d_ops[0].addr : 32'h0;
    d_wdata = (d_ops.size() > 0) ? d_ops[0].wdata : 32'h0;
  end

  always @(negedge clk) begin
    if (if_done && if_ops.size() > 0) void'(if_ops.pop_front());
    if (d_done && d_ops.size() > 0) void'(d_ops.pop_front());
  end

  // Memory: ready after mem_lat stall cycles; request must stay stable meanwhile.
  always @(negedge clk) begin
    if (mem_valid) begin
      if (wcnt == 0) begin
        lat_addr  = mem_addr;
        lat_we    = mem_we;
        lat_wdata = mem_wdata;
      end else begin
        check("mem_hold_addr", mem_addr, lat_addr);
        check("mem_hold_we", 32'(mem_we), 32'(lat_we));
        check("mem_hold_wdata", mem_wdata, lat_wdata);
      end
      last_addr  = mem_addr;
      last_we    = mem_we;
      last_wdata = mem_wdata;
      if (wcnt >= mem_lat) begin
        mem_ready   = 1'b1;
        mem_rdata   = mem_word(mem_addr);
        last_stalls = wcnt;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      wcnt      = 0;
    end
  end

  // Monitor: every done pulse consumes the next expected response in order.
  always @(negedge clk) begin
    if (if_done || d_done) begin
      check("done_exclusive", 32'(if_done & d_done), 32'd0);
      if (if_done) if_done_cyc = cyc;
      if (d_done) begin
        d_done_cyc = cyc;
        d_done_cnt++;
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: if_done=%0b d_done=%0b with no response pending", if_done, d_done);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_owner_is_d", 32'(d_done), 32'(mon_e.is_d));
        check("done_rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    int n;
    int cnt0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_d_done", 32'(d_done), 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, zero-latency memory: grant next cycle, done in third cycle.
    mem_lat = 0;
    if_ops.push_back(32'h10);
    exp_q.push_back('{1'b0, 32'h0000_0513});
    @(negedge clk);
    check("f1_idle_valid", 32'(mem_valid), 32'd0);
    check("f1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("f1_busy_valid", 32'(mem_valid), 32'd1);
    check("f1_busy_addr", mem_addr, 32'h10);
    check("f1_busy_we", 32'(mem_we), 32'd0);
    check("f1_busy_busy", 32'(busy), 32'd1);
    check("f1_busy_done", 32'(if_done), 32'd0);
    @(negedge clk);
    check("f1_resp_done", 32'(if_done), 32'd1);
    check("f1_resp_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    check("f1_after_done", 32'(if_done), 32'd0);
    drain("f1", 50);

    // Load to seed d_rdata, then a store with 5 stall cycles.
    d_ops.push_back('{1'b0, 32'h200, 32'h0});
    exp_q.push_back('{1'b1, 32'h1000_0200});
    drain("ld1", 50);
    mem_lat = 5;
    cnt0 = d_done_cnt;
    d_ops.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF});
    exp_q.push_back('{1'b1, 32'h1000_0200});
    drain("st1", 100);
    check("st1_stalls", 32'(last_stalls), 32'd5);
    check("st1_we", 32'(last_we), 32'd1);
    check("st1_addr", last_addr, 32'h100);
    check("st1_wdata", last_wdata, 32'hDEAD_BEEF);
    check("st1_done_count", 32'(d_done_cnt - cnt0), 32'd1);

    // Both requesters busy: D,D,D,D,I,D,D,D,D,I.
    mem_lat = 0;
    for (int k = 0; k < 8; k++) d_ops.push_back('{1'b0, 32'h300 + 32'(4 * k), 32'h0});
    if_ops.push_back(32'h40);
    if_ops.push_back(32'h44);
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b1, 32'h1000_0300 + 32'(4 * k)});
    exp_q.push_back('{1'b0, 32'h1000_0040});
    for (int k = 4; k < 8; k++) exp_q.push_back('{1'b1, 32'h1000_0300 + 32'(4 * k)});
    exp_q.push_back('{1'b0, 32'h1000_0044});
    drain("streak", 400);

    // Simultaneous from IDLE, streak cleared: data first, fetch 3 cycles later.
    if_ops.push_back(32'h80);
    d_ops.push_back('{1'b0, 32'h84, 32'h0});
    exp_q.push_back('{1'b1, 32'h1000_0084});
    exp_q.push_back('{1'b0, 32'h1000_0080});
    drain("simul", 100);
    check("simul_gap", 32'(if_done_cyc - d_done_cyc), 32'd3);

    // Reset during the second BUSY_D cycle; held load re-arbitrates afterwards.
    mem_lat = 20;
    cnt0 = d_done_cnt;
    d_ops.push_back('{1'b0, 32'h500, 32'h0});
    exp_q.push_back('{1'b1, 32'h1000_0500});
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_busy_seen", 32'(mem_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(mem_valid), 32'd0);
    check("rst_mid_d_done", 32'(d_done), 32'd0);
    mem_lat = 1;
    reset = 1'b0;
    drain("rst_mid", 100);
    check("rst_mid_done_count", 32'(d_done_cnt - cnt0), 32'd1);

`ifdef MEM_ARB_PERF_EN
    // Counters from reset: one fetch with 4 stall cycles waits 6 cycles.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_lat = 4;
    if_ops.push_back(32'h10);
    exp_q.push_back('{1'b0, 32'h0000_0513});
    drain("perf", 100);
    repeat (2) @(negedge clk);
    check("perf_if_wait", perf_if_wait, 32'd6);
    check("perf_d_wait", perf_d_wait, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined CPU.
- Serialises accesses: one outstanding transaction at a time.
- Gives data priority, with a bounded anti-starvation rule for fetch.
- Returns read data through registered one-cycle done pulses, which the pipeline's stall logic consumes.

Parameters:
AW, 32, address width (byte address, passed through unchanged)
DW, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending; range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; level, held until if_done
if_addr  input  AW  fetch address; stable while if_req high
if_done  output  1  one-cycle pulse, fetch complete
if_rdata  output  DW  fetched word; valid in the if_done cycle, held until the next if_done
d_req  input  1  data request; level, held until d_done
d_we  input  1  1 = store, 0 = load; stable while d_req high
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_done  output  1  one-cycle pulse, data access complete
d_rdata  output  DW  load data; valid in the d_done cycle (unchanged on stores)
mem_valid  output  1  request to memory; held until mem_ready
mem_we  output  1  write enable to memory
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_ready  input  1  memory completes the current request this cycle
mem_rdata  input  DW  memory read data; valid with mem_ready
busy  output  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, streak=0, all outputs 0, including if_rdata and d_rdata.
- States:
  - IDLE: evaluate requests.
  - BUSY_I: fetch in flight at memory.
  - BUSY_D: data access in flight at memory.
  - RESP: done pulse cycle.
- IDLE arbitration, registered (grant takes effect next cycle):
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both requesting and streak < MAX_D_STREAK -> BUSY_D.
  - Both requesting and streak == MAX_D_STREAK -> BUSY_I.
  - Neither -> stay in IDLE.
- On entering a BUSY state, latch the winner's address, we and wdata into the mem_* registers and set mem_valid=1. Fetch always drives mem_we=0.
- BUSY_x: hold mem_* stable while mem_ready=0; there is no timeout.
- When mem_ready=1 in BUSY_x:
  - mem_valid=0 next cycle.
  - Capture mem_rdata into if_rdata (BUSY_I) or d_rdata (BUSY_D loads only).
  - Assert the matching done for exactly one cycle; state -> RESP.
- RESP: requests are not sampled (the requester may drop or change its request in the done cycle); state -> IDLE.
- Minimum cost per access with mem_ready tied high: 3 cycles from request to done (IDLE sample, BUSY, RESP/done).
- Streak counter:
  - Increments on each data grant made while if_req=1, saturating at MAX_D_STREAK.
  - Clears to 0 on any fetch grant.
  - Clears to 0 on a data grant made while if_req=0.
- The done pulses if_done and d_done are never high together.
- A requester that drops its request before done, which is illegal, does not abort the transaction; the done pulse is still issued.
- Reset mid-transaction:
  - Next edge: state=IDLE, mem_valid=0, no done pulse.
  - The abandoned request is not reissued; memory must tolerate mem_valid dropping without mem_ready.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_if_wait[31:0] and perf_d_wait[31:0].
  - Each counts cycles in which its req=1 and its done=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State enum (IDLE, BUSY_I, BUSY_D, RESP).
  - Grant-owner encoding (OWN_I, OWN_D).
  - Default widths.
- One natural sub-module: arb_streak_counter, a saturating counter with clear/increment/limit that produces the force-fetch flag.
- The rest, FSM and registered mem_* and response paths, stays flat.

Test Plan:
- mem_ready=1 constant; if_req, if_addr=0x0000_0010; memory returns 0x0000_0513 -> mem_valid one cycle later with mem_addr=0x10 and mem_we=0; if_done pulses 3 cycles after request with if_rdata=0x0000_0513.
- d_req store, d_addr=0x100, d_wdata=0xDEADBEEF; mem_ready delayed 5 cycles -> mem_* held stable 5 cycles; mem_we=1; exactly one d_done; d_rdata unchanged.
- if_req and d_req held continuously with MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; no two done pulses in the same cycle.
- Simultaneous if_req and d_req from IDLE with streak=0 -> data granted first; fetch granted in the IDLE following the data RESP.
- reset asserted on cycle 2 of BUSY_D (mem_ready=0) -> next cycle state=IDLE, mem_valid=0, busy=0, no d_done; after release, a held d_req is re-arbitrated normally.
- MEM_ARB_PERF_EN defined; single fetch with mem_ready after 4 cycles -> perf_if_wait=6 after if_done, perf_d_wait=0.
